// File: rtl/circle_pkg.sv
// Shared constants for the midpoint circle plotter: FSM state codes and default screen size.
package circle_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_PLOT   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_SPAN   = 3'd5;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

endpackage

// File: rtl/circle_datapath.sv
// Midpoint-circle datapath: latched job, ox/oy/crit iterators, octant/span pixel generation and clipping.
module circle_datapath
  import circle_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned R_W      = 6,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           init,
  input  logic           step,
  input  logic           update,
  input  logic           span_mode,
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  input  logic [R_W-1:0] r,
  input  logic [2:0]     color_in,
  output logic [X_W-1:0] px_c,
  output logic [Y_W-1:0] py_c,
  output logic           on_screen_c,
  output logic           last_c,
  output logic           cont_c,
  output logic [2:0]     color_lat
);

  localparam int unsigned OW  = R_W + 2;
  localparam int unsigned CW  = R_W + 3;
  localparam int unsigned PXW = X_W + 2;
  localparam int unsigned PYW = Y_W + 2;
  localparam logic signed [PXW-1:0] SW_S = PXW'(SCREEN_W);
  localparam logic signed [PYW-1:0] SH_S = PYW'(SCREEN_H);

  logic [X_W-1:0]        cx_q, cx_d;
  logic [Y_W-1:0]        cy_q, cy_d;
  logic [R_W-1:0]        r_q, r_d;
  logic [2:0]            col_q, col_d;
  logic signed [OW-1:0]  ox_q, ox_d, oy_q, oy_d, so_q, so_d;
  logic signed [CW-1:0]  crit_q, crit_d;
  logic [2:0]            oct_q, oct_d;
  logic [1:0]            row_q, row_d;

  logic signed [PXW-1:0] cx_s, px_s;
  logic signed [PYW-1:0] cy_s, py_s;
  logic signed [OW-1:0]  dx, dy, half, dyv;
  logic                  crit_le0;

  // Current pixel: octant reflection in outline mode, running span offset in fill mode
  always_comb begin
    cx_s = PXW'(cx_q);
    cy_s = PYW'(cy_q);
    half = row_q[1] ? oy_q : ox_q;
    dyv  = row_q[1] ? ox_q : oy_q;
    dx   = oct_q[0] ? oy_q : ox_q;
    dy   = oct_q[0] ? ox_q : oy_q;
    if (span_mode) begin
      px_s   = cx_s + PXW'(so_q);
      py_s   = row_q[0] ? cy_s - PYW'(dyv) : cy_s + PYW'(dyv);
      last_c = (row_q == 2'd3) && (so_q == half);
    end else begin
      px_s   = (oct_q[1] ^ oct_q[2]) ? cx_s - PXW'(dx) : cx_s + PXW'(dx);
      py_s   = oct_q[2] ? cy_s - PYW'(dy) : cy_s + PYW'(dy);
      last_c = (oct_q == 3'd7);
    end
    on_screen_c = !px_s[PXW-1] && (px_s < SW_S) && !py_s[PYW-1] && (py_s < SH_S);
  end

  assign px_c      = px_s[X_W-1:0];
  assign py_c      = py_s[Y_W-1:0];
  assign color_lat = col_q;
  assign crit_le0  = crit_q[CW-1] | (crit_q == '0);

  always_comb begin
    cx_d   = cx_q;
    cy_d   = cy_q;
    r_d    = r_q;
    col_d  = col_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    so_d   = so_q;
    crit_d = crit_q;
    oct_d  = oct_q;
    row_d  = row_q;
    if (load) begin
      cx_d  = cx;
      cy_d  = cy;
      r_d   = r;
      col_d = color_in;
    end
    if (init) begin
      ox_d   = OW'(r_q);
      oy_d   = '0;
      crit_d = CW'(1) - CW'(r_q);
      oct_d  = '0;
      row_d  = '0;
      so_d   = '0 - OW'(r_q);
    end
    if (step) begin
      if (span_mode) begin
        if (so_q == half) begin
          row_d = row_q + 2'd1;
          so_d  = -(row_d[1] ? oy_q : ox_q);
        end else begin
          so_d = so_q + OW'(1);
        end
      end else begin
        oct_d = oct_q + 3'd1;
      end
    end
    // Midpoint step; the decision uses the already-incremented oy (and decremented ox)
    if (update) begin
      oy_d = oy_q + OW'(1);
      if (crit_le0) begin
        crit_d = crit_q + CW'(oy_d) + CW'(oy_d) + CW'(1);
      end else begin
        ox_d   = ox_q - OW'(1);
        crit_d = crit_q + CW'(oy_d) + CW'(oy_d) - CW'(ox_d) - CW'(ox_d) + CW'(1);
      end
      oct_d = '0;
      row_d = '0;
      so_d  = -ox_d;
    end
  end

  assign cont_c = (oy_d <= ox_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q   <= '0;
      cy_q   <= '0;
      r_q    <= '0;
      col_q  <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      so_q   <= '0;
      crit_q <= '0;
      oct_q  <= '0;
      row_q  <= '0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      r_q    <= r_d;
      col_q  <= col_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      so_q   <= so_d;
      crit_q <= crit_d;
      oct_q  <= oct_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle plotter FSM with registered pixel outputs.
// Optional filled-circle spans when CIRCLE_FILL_EN is defined (adds the fill input).
module circle_plotter
  import circle_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned R_W      = 6,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_sig,
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  input  logic [R_W-1:0] r,
  input  logic [2:0]     color_in,
`ifdef CIRCLE_FILL_EN
  input  logic           fill,
`endif
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     color,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  logic [2:0]     state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     color_q, color_d;
  logic           plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic           load, init, step, update, span_mode, pix;
  logic [X_W-1:0] px_c;
  logic [Y_W-1:0] py_c;
  logic           on_screen_c, last_c, cont_c;
  logic [2:0]     color_lat;

`ifdef CIRCLE_FILL_EN
  logic fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (load) fill_d = fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b0;
    else        fill_q <= fill_d;
  end

  assign span_mode = fill_q;
`else
  assign span_mode = 1'b0;
`endif

  circle_datapath #(
    .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) u_dp (
    .clk(clk), .rst_n(rst_n),
    .load(load), .init(init), .step(step), .update(update), .span_mode(span_mode),
    .cx(cx), .cy(cy), .r(r), .color_in(color_in),
    .px_c(px_c), .py_c(py_c), .on_screen_c(on_screen_c),
    .last_c(last_c), .cont_c(cont_c), .color_lat(color_lat)
  );

  // Next state, datapath strobes and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    init    = 1'b0;
    step    = 1'b0;
    update  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_sig) begin
                   state_d = ST_INIT;
                   load    = 1'b1;
                 end
      ST_INIT:   begin
                   init    = 1'b1;
                   state_d = span_mode ? ST_SPAN : ST_PLOT;
                 end
      ST_PLOT,
      ST_SPAN:   begin
                   step = 1'b1;
                   if (last_c) state_d = ST_UPDATE;
                 end
      ST_UPDATE: begin
                   update  = 1'b1;
                   state_d = cont_c ? (span_mode ? ST_SPAN : ST_PLOT) : ST_DONE;
                 end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    pix     = (state_q == ST_PLOT) || (state_q == ST_SPAN);
    plot_d  = pix && on_screen_c;
    x_d     = pix ? px_c : x_q;
    y_d     = pix ? py_c : y_q;
    color_d = color_lat;
    busy_d  = (state_q != ST_IDLE);
    done_d  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_circle_plotter.sv
// Self-checking bench for circle_plotter: table of known circles, hand-written corner sequences,
// and random circles checked cycle by cycle against a plain-integer midpoint-circle model.
module tb_circle_plotter;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned R_W = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_sig;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [R_W-1:0] r;
  logic [2:0]     color_in;
`ifdef CIRCLE_FILL_EN
  logic           fill;
`endif
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     color;
  logic           plot, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  circle_plotter #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n), .start_sig(start_sig),
    .cx(cx), .cy(cy), .r(r), .color_in(color_in),
`ifdef CIRCLE_FILL_EN
    .fill(fill),
`endif
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit pix; int px; int py; } ev_t;
  typedef struct {
    int cx; int cy; int r; int col;
    int ex0; int ey0; bit ep0;
    int ex1; int ey1; bit ep1;
    int elat;
  } vec_t;

  ev_t evq[$];
  int  cap_x[$], cap_y[$];
  bit  cap_p[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push_px(int px, int py);
    ev_t e;
    e.pix = 1'b1; e.px = px; e.py = py;
    evq.push_back(e);
  endfunction

  function automatic void push_row(int cxv, int yv, int half);
    for (int d = -half; d <= half; d++) push_px(cxv + d, yv);
  endfunction

  // Reference: list of per-cycle events (pixel or idle update cycle) from the midpoint rules
  function automatic void build(int cxv, int cyv, int rv, bit fl);
    int ox;
    int oy;
    int crit;
    ev_t gap;
    ox = rv; oy = 0; crit = 1 - rv;
    gap.pix = 1'b0; gap.px = 0; gap.py = 0;
    evq.delete();
    do begin
      if (fl) begin
        push_row(cxv, cyv + oy, ox);
        push_row(cxv, cyv - oy, ox);
        push_row(cxv, cyv + ox, oy);
        push_row(cxv, cyv - ox, oy);
      end else begin
        push_px(cxv + ox, cyv + oy);
        push_px(cxv + oy, cyv + ox);
        push_px(cxv - ox, cyv + oy);
        push_px(cxv - oy, cyv + ox);
        push_px(cxv - ox, cyv - oy);
        push_px(cxv - oy, cyv - ox);
        push_px(cxv + ox, cyv - oy);
        push_px(cxv + oy, cyv - ox);
      end
      evq.push_back(gap);
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endfunction

  function automatic bit on_screen(int px, int py);
    return (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
  endfunction

  task automatic run_circle(input int cxv, input int cyv, input int rv, input int col,
                            input bit fl, input bit hold, input string tag, output int lat);
    int len;
    int bad;
    build(cxv, cyv, rv, fl);
    len = evq.size();
    cap_x.delete(); cap_y.delete(); cap_p.delete();
    lat = -1;
    bad = 0;
    @(negedge clk);
    cx        = X_W'(cxv);
    cy        = Y_W'(cyv);
    r         = R_W'(rv);
    color_in  = 3'(col);
`ifdef CIRCLE_FILL_EN
    fill      = fl;
`endif
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_sig = 1'b0;
    for (int n = 1; n <= len + 3; n++) begin
      bit ep;
      bit epix;
      int ex;
      int ey;
      @(posedge clk);
      @(negedge clk);
      epix = 1'b0; ex = 0; ey = 0;
      if (n >= 2 && n <= len + 1) begin
        epix = evq[n-2].pix;
        ex   = evq[n-2].px;
        ey   = evq[n-2].py;
      end
      ep = epix && on_screen(ex, ey);
      chk($sformatf("%s flags n=%0d {color,done,busy,plot}", tag, n),
          {26'd0, color, done, busy, plot},
          {26'd0, 3'(col), (n == len + 2), (n <= len + 2), ep});
      if (epix) begin
        chk($sformatf("%s x n=%0d", tag, n), int'(x), ex & 255);
        chk($sformatf("%s y n=%0d", tag, n), int'(y), ey & 127);
        cap_x.push_back(int'(x));
        cap_y.push_back(int'(y));
        cap_p.push_back(plot);
      end
      if (done && lat < 0) lat = n;
      if (plot && (x >= 160 || y >= 120)) bad++;
    end
    chk($sformatf("%s plotted pixel off screen", tag), bad, 0);
  endtask

  vec_t vecs[5];
  int   e35x[16];
  int   e35y[16];
  int   lat;
  int   cnt;
  int   px_q[$], py_q[$];

  initial begin
    vecs[0] = '{10, 10, 1, 3, 11, 10, 1'b1, 10, 11, 1'b1, 20};
    vecs[1] = '{5, 5, 0, 5, 5, 5, 1'b1, 5, 5, 1'b1, 11};
    vecs[2] = '{80, 60, 60, 7, 140, 60, 1'b1, 80, 120, 1'b0, -1};
    vecs[3] = '{0, 0, 3, 1, 3, 0, 1'b1, 0, 3, 1'b1, 29};
    vecs[4] = '{159, 119, 5, 2, 164, 119, 1'b0, 159, 124, 1'b0, -1};
    e35x = '{11, 10, 9, 10, 9, 10, 11, 10, 11, 11, 9, 9, 9, 9, 11, 11};
    e35y = '{10, 11, 10, 11, 10, 9, 10, 9, 11, 11, 11, 11, 9, 9, 9, 9};

    rst_n = 1'b0; start_sig = 1'b0; cx = '0; cy = '0; r = '0; color_in = '0;
`ifdef CIRCLE_FILL_EN
    fill = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset {x,y,color,plot,busy,done}", {14'd0, x, y, color, plot, busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_circle(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].col, 1'b0, 1'b0,
                 $sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d pixel0 x", i), cap_x[0], vecs[i].ex0);
      chk($sformatf("vec%0d pixel0 y", i), cap_y[0], vecs[i].ey0);
      chk($sformatf("vec%0d pixel0 plot", i), int'(cap_p[0]), int'(vecs[i].ep0));
      chk($sformatf("vec%0d pixel1 x", i), cap_x[1], vecs[i].ex1);
      chk($sformatf("vec%0d pixel1 y", i), cap_y[1], vecs[i].ey1);
      chk($sformatf("vec%0d pixel1 plot", i), int'(cap_p[1]), int'(vecs[i].ep1));
      if (vecs[i].elat >= 0) chk($sformatf("vec%0d done latency", i), lat, vecs[i].elat);
    end

    // Reset in the middle of the first octant sweep
    @(negedge clk);
    cx = 8'd10; cy = 7'd10; r = 6'd1; color_in = 3'd6; start_sig = 1'b1;
    @(posedge clk);
    #1 start_sig = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre-reset {plot,busy}", {30'd0, plot, busy}, 3);
    rst_n = 1'b0;
    #1;
    chk("mid-draw reset {x,y,color,plot,busy,done}", {14'd0, x, y, color, plot, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("activity after aborted draw", cnt, 0);

    run_circle(10, 10, 1, 4, 1'b0, 1'b0, "r1_after_reset", lat);
    chk("r1_after_reset done latency", lat, 20);
    px_q.delete(); py_q.delete();
    foreach (cap_p[i]) if (cap_p[i]) begin
      px_q.push_back(cap_x[i]);
      py_q.push_back(cap_y[i]);
    end
    chk("r1 plotted pixel count", px_q.size(), 16);
    for (int i = 0; i < 16 && i < px_q.size(); i++) begin
      chk($sformatf("r1 plotted x[%0d]", i), px_q[i], e35x[i]);
      chk($sformatf("r1 plotted y[%0d]", i), py_q[i], e35y[i]);
    end

    // start_sig held high across a draw: one done, then a new circle from IDLE
    run_circle(20, 30, 2, 1, 1'b0, 1'b1, "held_start", lat);
    @(posedge clk);
    @(negedge clk);
    chk("held_start second circle busy", int'(busy), 1);
    start_sig = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200 && cnt == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) cnt = 1;
    end
    chk("held_start second circle done", cnt, 1);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      int rc;
      int rcy;
      int rr;
      int rcol;
      bit rf;
      rc   = int'($urandom_range(0, 255));
      rcy  = int'($urandom_range(0, 127));
      rr   = int'($urandom_range(0, 63));
      rcol = int'($urandom_range(0, 7));
      rf   = 1'b0;
`ifdef CIRCLE_FILL_EN
      rf   = 1'($urandom_range(0, 1));
`endif
      run_circle(rc, rcy, rr, rcol, rf, 1'b0, $sformatf("rand%0d", i), lat);
    end

`ifdef CIRCLE_FILL_EN
    run_circle(10, 10, 1, 5, 1'b1, 1'b0, "fill_r1", lat);
    chk("fill_r1 span x0", cap_x[0], 9);
    chk("fill_r1 span x1", cap_x[1], 10);
    chk("fill_r1 span x2", cap_x[2], 11);
    chk("fill_r1 span y0", cap_y[0], 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/circle_plotter.md
CIRCLE_PLOTTER -- requirements
Module: circle_plotter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): X_W, 8, x coordinate width.
REQ-002 Y_W, 7, y coordinate width.
REQ-003 R_W, 6, radius width.
REQ-004 SCREEN_W, 160, visible columns.
REQ-005 SCREEN_H, 120, visible rows.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk, input, 1, sole clock (one clock).
REQ-007 rst_n, input, 1, asynchronous active-low reset.
REQ-008 start_sig, input, 1, start request.
REQ-009 cx, input, X_W, centre x.
REQ-010 cy, input, Y_W, centre y.
REQ-011 r, input, R_W, radius.
REQ-012 color_in, input, 3, pixel colour.
REQ-013 x, output, X_W, pixel x.
REQ-014 y, output, Y_W, pixel y.
REQ-015 color, output, 3, pixel colour.
REQ-016 plot, output, 1, write x/y/color this cycle.
REQ-017 busy, output, 1, drawing in progress.
REQ-018 done, output, 1, one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, INIT, PLOT, UPDATE, DONE; IDLE->INIT on start_sig=1 at a clk rising edge.
REQ-020 cx, cy, r, color_in (and fill) SHALL be latched when start is accepted; start_sig outside IDLE SHALL be ignored.
REQ-021 INIT (1 cycle): ox=r, oy=0, crit=1-r; crit signed, R_W+3 bits; pixel sums signed, X_W+2 / Y_W+2 bits.
REQ-022 PLOT (8 cycles, octant index k=0..7 in order): (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+ox,cy-oy), (cx+oy,cy-ox).
REQ-023 Clipping: plot=1 only if 0<=px<SCREEN_W and 0<=py<SCREEN_H; a clipped pixel still consumes its cycle with plot=0; x/y show the low bits of px/py.
REQ-024 UPDATE (1 cycle): oy+=1; if crit<=0 then crit+=2*oy+1 else ox-=1, crit+=2*(oy-ox)+1 (new values); then PLOT if oy<=ox else DONE.
REQ-025 DONE (1 cycle): done=1, then IDLE; busy=1 in INIT, PLOT, UPDATE, DONE.
REQ-026 Duplicate pixels (oy=0, ox=oy) SHALL NOT be suppressed; r=0 plots the centre 8 times.
REQ-027 Outside PLOT (or fill span), plot=0; color equals the latched colour.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, plot=0, busy=0, done=0, x=0, y=0, color=0, all internal registers to 0.
REQ-029 Reset mid-draw SHALL abort without a done pulse; the next start begins a fresh circle.

Configuration
REQ-030 Macro CIRCLE_FILL_EN SHALL add input fill (1 bit, latched at start).
REQ-031 With CIRCLE_FILL_EN and fill=1, each iteration SHALL replace PLOT with SPAN: rows cy+oy, cy-oy over cx-ox..cx+ox, then rows cy+ox, cy-ox over cx-oy..cx+oy, one pixel per cycle, ascending x, same clipping.
REQ-032 Without CIRCLE_FILL_EN (or fill=0), behaviour SHALL be outline only, exactly per REQ-022.

Structure
REQ-033 Package circle_pkg SHALL hold the state enum and default screen constants.
REQ-034 Sub-module circle_datapath SHALL hold ox/oy/crit registers and pixel/clip arithmetic; circle_plotter holds the FSM.

Verification
REQ-035 r=1, c=(10,10), start 1 cycle -> plot sequence (11,10),(10,11),(9,10),(10,11),(9,10),(10,9),(11,10),(10,9), then (11,11)x2,(9,11)x2,(9,9)x2,(11,9)x2; done 20 cycles after start accepted.
REQ-036 r=60, c=(80,60) -> first PLOT pixel (140,60) plot=1; second (80,120) plot=0 (clipped); every plotted pixel satisfies x<160, y<120.
REQ-037 r=0, c=(5,5) -> 8 plot pulses at (5,5), done 11 cycles after start.
REQ-038 start_sig held high during draw -> single done pulse; second circle only after IDLE.
REQ-039 rst_n low during PLOT -> plot/busy drop immediately, no done; next start r=1 repeats REQ-035.
REQ-040 CIRCLE_FILL_EN, fill=1, r=1, c=(10,10) -> first span (9,10),(10,10),(11,10); busy held through all spans.
